// File: rtl/gpu_pkg.sv
// ============================================================================
//  Module   : gpu_pkg
//  Brief    : Shared types and defaults for the memory-channel arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package gpu_pkg;

    localparam int c_DEF_ADDR_BITS = 8;
    localparam int c_DEF_DATA_BITS = 8;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2,
        ST_RELEASE = 2'd3
    } mem_arb_state_t;

    // Index width for a vector of n entries; never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational rotating-priority picker. Returns the first set
//             request at or after i_ptr (wrapping) as one-hot and as index.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 2
)(
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [idx_width(NUM_REQ)-1:0]  i_ptr,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic [idx_width(NUM_REQ)-1:0]  o_idx,
    output logic                           o_any
);

    localparam int c_IDX_W = idx_width(NUM_REQ);

    // Doubling the request vector turns the wrap-around search into a
    // plain slice starting at the pointer.
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [c_IDX_W:0]     w_sum;

    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: NUM_REQ];
    assign o_any = |i_req;

    // Lowest set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        w_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (c_IDX_W+1)'(k);
            end
        end
        if (w_sum >= (c_IDX_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (c_IDX_W+1)'(NUM_REQ);
        end
    end

    assign o_idx   = w_sum[c_IDX_W-1:0];
    assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Round-robin arbiter sharing one memory channel between
//             NUM_REQ requesters. One transaction at a time:
//             IDLE -> ISSUE -> RESPOND -> RELEASE -> IDLE.
//             Optional ISSUE watchdog enabled by macro MEM_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_BITS      = c_DEF_ADDR_BITS,
    parameter int DATA_BITS      = c_DEF_DATA_BITS,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_rdata,
    output logic                               mem_valid,
    output logic                               mem_write,
    output logic [ADDR_BITS-1:0]               mem_addr,
    output logic [DATA_BITS-1:0]               mem_wdata,
    input  logic                               mem_ready,
    input  logic [DATA_BITS-1:0]               mem_rdata,
    output logic                               timeout_err
);

    localparam int c_IDX_W = idx_width(NUM_REQ);

    mem_arb_state_t        r_state;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_IDX_W-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_gnt_oh;

    logic [NUM_REQ-1:0]    w_grant;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_any;
    logic [c_IDX_W-1:0]    w_next_ptr;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0]    r_to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Priority moves to the requester after the one just served
    assign w_next_ptr = (r_gnt == c_IDX_W'(NUM_REQ - 1)) ? '0 : (r_gnt + 1'b1);

    // Transaction sequencer; every output is registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_gnt_oh  <= '0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_ready <= '0;
            req_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            // Completion strobes are single-cycle pulses
            req_ready <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_idx;
                        r_gnt_oh  <= w_grant;
                        mem_write <= req_write[w_idx];
                        mem_addr  <= req_addr[w_idx];
                        mem_wdata <= req_wdata[w_idx];
                        mem_valid <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!mem_write) begin
                            req_rdata[r_gnt] <= mem_rdata;
                        end
                        req_ready <= r_gnt_oh;
                        r_state   <= ST_RESPOND;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Memory gave no answer: complete with an error and zero data
                    else if (r_to_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_valid   <= 1'b0;
                        timeout_err <= 1'b1;
                        req_ready   <= r_gnt_oh;
                        if (!mem_write) begin
                            req_rdata[r_gnt] <= '0;
                        end
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= ST_RELEASE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                ST_RESPOND: begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    // Wait for the served requester to retract before rearbitrating
                    if (!(|(req_valid & r_gnt_oh))) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter (NUM_REQ=2, 8-bit fields).
//             Directed vector table, multi-cycle corner sequences, and a
//             randomized run against a round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_N = 2;

    logic                     clk;
    logic                     reset;
    logic [c_N-1:0]           req_valid;
    logic [c_N-1:0]           req_write;
    logic [c_N-1:0][7:0]      req_addr;
    logic [c_N-1:0][7:0]      req_wdata;
    logic [c_N-1:0]           req_ready;
    logic [c_N-1:0][7:0]      req_rdata;
    logic                     mem_valid;
    logic                     mem_write;
    logic [7:0]               mem_addr;
    logic [7:0]               mem_wdata;
    logic                     mem_ready;
    logic [7:0]               mem_rdata;
    logic                     timeout_err;

    int         n_cmp;
    int         n_fail;
    bit         mem_en;
    int         mem_lat;
    int         mem_cnt;
    logic [7:0] mem_next;

    typedef struct {
        bit         rst;
        logic [1:0] valid;
        logic [1:0] wr;
        logic [7:0] a0, a1, d0, d1;
        int         lat;
        logic [7:0] rd;
        int         eg;
        logic [7:0] eaddr;
        logic       ewr;
        logic [7:0] ewd;
        logic [7:0] erd;
    } vec_t;

    vec_t vt[8];

    mem_arbiter #(
        .NUM_REQ        (c_N),
        .ADDR_BITS      (8),
        .DATA_BITS      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .mem_valid   (mem_valid),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock; then the memory model reacts to what the DUT presents
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_valid && mem_en) begin
            if (mem_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_next;
                mem_cnt   = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_cnt   = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drive one table vector to completion and check the memory and response sides
    task automatic run_vec(input vec_t v, input int id);
        int n;
        if (v.rst) begin
            req_valid = '0;
            do_reset();
        end
        req_write    = v.wr;
        req_addr[0]  = v.a0;
        req_addr[1]  = v.a1;
        req_wdata[0] = v.d0;
        req_wdata[1] = v.d1;
        req_valid    = v.valid;
        mem_lat      = v.lat;
        mem_next     = v.rd;
        mem_en       = 1'b1;
        step();
        chk($sformatf("v%0d_issue_lat", id), mem_valid, 1);
        n = 0;
        while (!mem_valid && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("v%0d_mem_addr", id), mem_addr, v.eaddr);
        chk($sformatf("v%0d_mem_write", id), mem_write, v.ewr);
        chk($sformatf("v%0d_mem_wdata", id), mem_wdata, v.ewd);
        n = 0;
        while (req_ready == '0 && n < 40) begin
            step();
            n++;
        end
        chk($sformatf("v%0d_req_ready", id), req_ready, 32'd1 << v.eg);
        chk($sformatf("v%0d_mem_valid_drop", id), mem_valid, 0);
        chk($sformatf("v%0d_rdata", id), req_rdata[v.eg], v.erd);
        chk($sformatf("v%0d_timeout", id), timeout_err, 0);
        req_valid[v.eg] = 1'b0;
        step();
        chk($sformatf("v%0d_ready_pulse", id), req_ready, 0);
        step();
    endtask

    initial begin
        int         n;
        int         good;
        int         exp_ptr;
        int         cur_g;
        int         eg;
        int         p;
        int         idle_cyc;
        int         to_seen;
        logic [7:0] cur_data;
        logic       prev_mv;
        int         hold[c_N];
        int         waitc[c_N];
        bit         pend[c_N];
        logic [7:0] exp_rd[c_N];
        vec_t       vp;

        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_en    = 1'b1;
        mem_lat   = 0;
        mem_cnt   = 0;
        mem_next  = '0;

        //                rst valid  wr     a0     a1     d0     d1     lat rd     eg eaddr  ewr ewd    erd
        vt[0] = '{1'b0, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 3, 8'hAB, 0, 8'h10, 1'b0, 8'h00, 8'hAB};
        vt[1] = '{1'b1, 2'b11, 2'b00, 8'h30, 8'h31, 8'h00, 8'h00, 1, 8'h11, 0, 8'h30, 1'b0, 8'h00, 8'h11};
        vt[2] = '{1'b0, 2'b10, 2'b00, 8'h30, 8'h31, 8'h00, 8'h00, 2, 8'h22, 1, 8'h31, 1'b0, 8'h00, 8'h22};
        vt[3] = '{1'b0, 2'b11, 2'b00, 8'h40, 8'h41, 8'h00, 8'h00, 0, 8'h33, 0, 8'h40, 1'b0, 8'h00, 8'h33};
        vt[4] = '{1'b0, 2'b11, 2'b00, 8'h50, 8'h41, 8'h00, 8'h00, 1, 8'h44, 1, 8'h41, 1'b0, 8'h00, 8'h44};
        vt[5] = '{1'b0, 2'b11, 2'b00, 8'h50, 8'h42, 8'h00, 8'h00, 2, 8'h55, 0, 8'h50, 1'b0, 8'h00, 8'h55};
        vt[6] = '{1'b0, 2'b10, 2'b00, 8'h50, 8'h42, 8'h00, 8'h00, 2, 8'h66, 1, 8'h42, 1'b0, 8'h00, 8'h66};
        vt[7] = '{1'b0, 2'b10, 2'b10, 8'h50, 8'h22, 8'h00, 8'h5C, 0, 8'h99, 1, 8'h22, 1'b1, 8'h5C, 8'h66};

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_req_rdata", req_rdata, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i], i);
        end

        // mem_ready while idle must not produce a response or touch read data
        mem_rdata = 8'hEE;
        mem_ready = 1'b1;
        step();
        chk("spur_req_ready", req_ready, 0);
        chk("spur_mem_valid", mem_valid, 0);
        chk("spur_rdata0", req_rdata[0], 8'h55);
        chk("spur_rdata1", req_rdata[1], 8'h66);
        step();
        chk("spur_req_ready2", req_ready, 0);

        // Reset in the middle of ISSUE abandons the transaction
        mem_en      = 1'b0;
        req_write   = '0;
        req_addr[0] = 8'h77;
        req_valid   = 2'b01;
        step();
        chk("mid_issue_valid", mem_valid, 1);
        repeat (4) step();
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_valid", mem_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        mem_ready = 1'b0;
        mem_cnt   = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_a", req_ready, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_ready_b", req_ready, 0);
        reset    = 1'b0;
        mem_en   = 1'b1;
        mem_lat  = 1;
        mem_next = 8'h3C;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            step();
            n++;
        end
        chk("post_rst_ready", req_ready, 2'b01);
        chk("post_rst_rdata", req_rdata[0], 8'h3C);
        req_valid = '0;
        step();
        step();

        // Give requester 1 nonzero read data, then stall memory forever
        vp = '{1'b0, 2'b10, 2'b00, 8'h00, 8'h12, 8'h00, 8'h00, 1, 8'hC7, 1, 8'h12, 1'b0, 8'h00, 8'hC7};
        run_vec(vp, 8);
        mem_en      = 1'b0;
        req_addr[1] = 8'h13;
        req_valid   = 2'b10;
        step();
        chk("stall_issue", mem_valid, 1);
`ifdef MEM_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 40) begin
            step();
            n++;
        end
        chk("to_cycles", n, 16);
        chk("to_req_ready", req_ready, 2'b10);
        chk("to_mem_valid", mem_valid, 0);
        chk("to_rdata_zero", req_rdata[1], 0);
        req_valid = '0;
        step();
        chk("to_pulse_err", timeout_err, 0);
        chk("to_pulse_ready", req_ready, 0);
        step();
`else
        good = 0;
        repeat (40) begin
            step();
            if (mem_valid && !timeout_err && req_ready == '0) good++;
        end
        chk("stall_holds", good, 40);
        chk("stall_rdata", req_rdata[1], 8'hC7);
        req_valid = '0;
        do_reset();
`endif

        // Randomized traffic against a round-robin reference model
        req_valid = '0;
        do_reset();
        mem_en   = 1'b1;
        mem_lat  = $urandom_range(0, 3);
        mem_next = 8'($urandom);
        exp_ptr  = 0;
        cur_g    = -1;
        cur_data = '0;
        prev_mv  = 1'b0;
        idle_cyc = 0;
        to_seen  = 0;
        for (int i = 0; i < c_N; i++) begin
            hold[i]   = 0;
            waitc[i]  = 0;
            pend[i]   = 1'b0;
            exp_rd[i] = '0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            if (timeout_err) to_seen++;
            if (mem_ready) begin
                cur_data = mem_rdata;
                mem_next = 8'($urandom);
                mem_lat  = $urandom_range(0, 3);
            end
            if (mem_valid && !prev_mv) begin
                eg = -1;
                for (int k = 0; k < c_N; k++) begin
                    p = (exp_ptr + k) % c_N;
                    if (eg < 0 && pend[p]) eg = p;
                end
                chk("rnd_overlap", (cur_g < 0), 1);
                chk("rnd_has_req", (eg >= 0), 1);
                if (eg >= 0) begin
                    chk("rnd_addr", mem_addr, req_addr[eg]);
                    chk("rnd_write", mem_write, req_write[eg]);
                    chk("rnd_wdata", mem_wdata, req_wdata[eg]);
                    for (int k = 0; k < c_N; k++) begin
                        if (k != eg && pend[k]) begin
                            waitc[k]++;
                            chk("rnd_starve", (waitc[k] <= c_N - 1), 1);
                        end
                    end
                    cur_g = eg;
                end
            end
            if (req_ready != '0) begin
                chk("rnd_ready", req_ready, (cur_g >= 0) ? (32'd1 << cur_g) : 32'd0);
                if (cur_g >= 0) begin
                    if (!req_write[cur_g]) exp_rd[cur_g] = cur_data;
                    for (int k = 0; k < c_N; k++) begin
                        chk("rnd_rdata", req_rdata[k], exp_rd[k]);
                    end
                    exp_ptr          = (cur_g + 1) % c_N;
                    pend[cur_g]      = 1'b0;
                    req_valid[cur_g] = 1'b0;
                    hold[cur_g]      = 2;
                    cur_g            = -1;
                end
                idle_cyc = 0;
            end
            idle_cyc++;
            if (idle_cyc > 100) begin
                chk("rnd_progress", idle_cyc, 0);
                break;
            end
            for (int i = 0; i < c_N; i++) begin
                if (!pend[i]) begin
                    if (hold[i] > 0) begin
                        hold[i]--;
                    end else if ($urandom_range(0, 2) == 0) begin
                        pend[i]      = 1'b1;
                        waitc[i]     = 0;
                        req_write[i] = 1'($urandom_range(0, 1));
                        req_addr[i]  = 8'(i * 128 + $urandom_range(0, 127));
                        req_wdata[i] = 8'($urandom);
                        req_valid[i] = 1'b1;
                    end
                end
            end
            prev_mv = mem_valid;
        end
        chk("rnd_no_timeout", to_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesting cores/LSUs sharing one memory channel.
REQ-002 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit (used only with MEM_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester request pending, held until served.
REQ-008 SHALL have port req_write  input  NUM_REQ  per-requester 1=write, 0=read.
REQ-009 SHALL have port req_addr  input  ADDR_BITS x NUM_REQ  per-requester address.
REQ-010 SHALL have port req_wdata  input  DATA_BITS x NUM_REQ  per-requester write data.
REQ-011 SHALL have port req_ready  output  NUM_REQ  one-cycle completion pulse per requester.
REQ-012 SHALL have port req_rdata  output  DATA_BITS x NUM_REQ  per-requester read data.
REQ-013 SHALL have port mem_valid  output  1  memory request strobe.
REQ-014 SHALL have ports mem_write (1), mem_addr (ADDR_BITS), mem_wdata (DATA_BITS)  output  request fields.
REQ-015 SHALL have port mem_ready  input  1  memory completion, one cycle.
REQ-016 SHALL have port mem_rdata  input  DATA_BITS  read data valid with mem_ready.
REQ-017 SHALL have port timeout_err  output  1  one-cycle watchdog pulse.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> RESPOND -> RELEASE -> IDLE.
REQ-019 IDLE: if any req_valid set, grant the first set bit at or after rr_ptr (wrapping), latch its write/addr/wdata, go ISSUE next cycle; else stay.
REQ-020 ISSUE: mem_valid=1 with latched fields, registered; first mem_valid exactly 1 cycle after the grant-sampling edge.
REQ-021 ISSUE: on mem_ready, deassert mem_valid next cycle, capture mem_rdata into req_rdata[g] for reads, go RESPOND.
REQ-022 RESPOND: req_ready[g]=1 for exactly one cycle, go RELEASE.
REQ-023 RELEASE: wait until req_valid[g]=0, then go IDLE; rr_ptr = (g+1) mod NUM_REQ updated on entry to RELEASE.
REQ-024 req_rdata[g] SHALL hold until the next read completion for g; writes leave it unchanged.
REQ-025 Requests arriving in non-IDLE states SHALL wait; none dropped; no requester starved (max wait NUM_REQ-1 transactions).
REQ-026 mem_ready outside ISSUE SHALL be ignored.
REQ-027 At most one req_ready bit set in any cycle.

Reset
REQ-028 On reset: state=IDLE, rr_ptr=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, req_ready=0, all req_rdata=0, timeout_err=0, immediately (asynchronous).
REQ-029 Reset mid-transaction SHALL abandon it without any req_ready pulse.

Configuration
REQ-030 Macro MEM_ARB_TIMEOUT_EN defined: cycle counter in ISSUE; if mem_ready absent for TIMEOUT_CYCLES cycles, drop mem_valid, pulse timeout_err and req_ready[g] together, req_rdata[g]=0 for reads, go RELEASE.
REQ-031 Macro undefined: no counter, ISSUE waits indefinitely, timeout_err tied 0.

Structure
REQ-032 Shared package gpu_pkg SHALL hold mem_arb_state_t enum and default ADDR_BITS/DATA_BITS constants.
REQ-033 SHALL use one sub-module rr_arbiter: combinational rotating-priority pick (req vector, rr_ptr -> one-hot grant, grant index, any).

Verification (NUM_REQ=2, TIMEOUT_CYCLES=16)
REQ-034 Single read: req_valid=01, addr=0x10; memory mem_ready 3 cycles after mem_valid with 0xAB -> mem_addr=0x10, req_ready=01 one cycle, req_rdata[0]=0xAB.
REQ-035 Simultaneous: req_valid=11 after reset -> core 0 served first, core 1 second, rr_ptr=0 after both.
REQ-036 Fairness: core 0 re-requests immediately after each completion, core 1 held high -> grants alternate 0,1,0,1.
REQ-037 Write: req_write[1]=1, addr=0x22, wdata=0x5C -> mem_write=1, mem_wdata=0x5C, req_rdata[1] unchanged.
REQ-038 Reset asserted in ISSUE -> mem_valid=0 same cycle, no req_ready pulse, IDLE after release.
REQ-039 With MEM_ARB_TIMEOUT_EN, memory never ready -> timeout_err and req_ready[g] pulse after 16 ISSUE cycles, req_rdata[g]=0.
